ram_loader: RTL and testbench
=============================

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter DATA_W, default 16, sets the word width of the storage array and data ports.
REQ-002 Parameter ADDR_W, default 4, sets the address width; depth is 2**ADDR_W (16 words).
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to begin a load burst; sampled only in IDLE.
REQ-006 base  input  ADDR_W  first write address of the burst; captured with start.
REQ-007 len  input  ADDR_W+1  number of words in the burst, 0..16; captured with start.
REQ-008 in_valid  input  1  in_data holds a word offered for writing.
REQ-009 in_data  input  DATA_W  write data.
REQ-010 in_ready  output  1  block accepts a word this cycle.
REQ-011 addr  input  ADDR_W  read address, asynchronous read port.
REQ-012 spo  output  DATA_W  array word at addr, combinational.
REQ-013 busy  output  1  high in LOAD.
REQ-014 done  output  1  one-cycle pulse at burst end.
REQ-015 wr_cnt  output  ADDR_W+1  words written in the current or last burst.
REQ-016 sum  output  DATA_W  modulo-2**DATA_W sum of words written in the current or last burst.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, LOAD, DONE.
REQ-018 In IDLE with start=1 and len!=0: capture base and len, clear wr_cnt and sum, go to LOAD on the next edge.
REQ-019 In IDLE with start=1 and len=0: clear wr_cnt and sum, go directly to DONE, no write.
REQ-020 in_ready SHALL be 1 only in LOAD, as a Moore output; busy SHALL equal in_ready.
REQ-021 A write occurs on an edge where in_valid=1 and in_ready=1: array[ptr] <= in_data, ptr <= ptr+1 mod 16, wr_cnt +1, sum <= sum+in_data truncated to DATA_W.
REQ-022 ptr SHALL start at base; the address wraps from 15 to 0 without error.
REQ-023 The write that makes wr_cnt equal len SHALL move the FSM from LOAD to DONE on the same edge.
REQ-024 in_valid=0 in LOAD SHALL stall the FSM indefinitely, with no write and no count change.
REQ-025 DONE SHALL last exactly one cycle with done=1, then go to IDLE; done SHALL be 0 in all other states.
REQ-026 start SHALL be ignored in LOAD and DONE; in_valid SHALL be ignored outside LOAD.
REQ-027 spo SHALL be purely combinational from addr and the array.
REQ-028 When reading and writing the same address in one cycle, spo shows the old word before the edge and the new word after it.
REQ-029 wr_cnt and sum SHALL hold their values in IDLE until the next accepted start.
REQ-030 Back-to-back bursts are allowed: start may be asserted in the IDLE cycle that directly follows DONE.

Reset
REQ-031 On rst_n=0, immediately and independent of clk:
- state=IDLE, ptr=0, wr_cnt=0, sum=0
- every array word = 0
- in_ready=0, busy=0, done=0
- spo=0 for any addr
REQ-032 Reset asserted during LOAD SHALL abort the burst with no done pulse; a partial burst leaves no written words after reset.
REQ-033 After rst_n rises, the first accepted start is the one sampled on the first rising edge with rst_n=1.

Verification
REQ-034 Reset, then sweep addr 0..15 -> spo=0x0000 at every address, in_ready=0, done=0.
REQ-035 start, base=0, len=16, in_valid held high with in_data=0x1000+i -> 16 writes on consecutive cycles, done pulses one cycle after the last write, wr_cnt=16, sum=0x0078; readback addr i -> 0x1000+i.
REQ-036 start, base=14, len=4, data A,B,C,D -> words land at addresses 14,15,0,1 (wrap-around); address 2 is unchanged.
REQ-037 LOAD with in_valid toggled 1,0,0,1,..., len=3 -> writes only on valid cycles, in_ready stays 1 throughout, done after the 3rd write; a start pulse mid-burst is ignored.
REQ-038 start with len=0 -> done pulses on the next cycle, wr_cnt=0, sum=0, array unchanged.
REQ-039 rst_n pulsed low after 2 of 5 writes -> all outputs 0 immediately, no done pulse, array reads all zero.

Source files
------------

// File: rtl/ram_loader.sv
// Burst loader into a 2**ADDR_W-word register array with an asynchronous read port.
// A start in IDLE captures base/len, then LOAD accepts len words before a one-cycle DONE.
module ram_loader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] spo,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_cnt,
  output logic [DATA_W-1:0] sum
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              in_ready_q, in_ready_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   cnt_inc;
  logic              we;
  logic [DATA_W-1:0] mem_q [Depth];

  assign cnt_inc = wr_cnt_q + (ADDR_W + 1)'(1);
  assign we      = (state_q == StLoad) && in_valid;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    wr_cnt_d = wr_cnt_q;
    sum_d    = sum_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          wr_cnt_d = '0;
          sum_d    = '0;
          if (len != '0) begin
            ptr_d   = base;
            len_d   = len;
            state_d = StLoad;
          end else begin
            state_d = StDone;
          end
        end
      end
      StLoad: begin
        if (in_valid) begin
          ptr_d    = ptr_q + ADDR_W'(1);
          wr_cnt_d = cnt_inc;
          sum_d    = sum_q + in_data;
          // The write that completes the burst leaves LOAD on the same edge.
          if (cnt_inc == len_q) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Outputs are registered copies of the next state, so they stay pure Moore.
    in_ready_d = (state_d == StLoad);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      len_q      <= '0;
      wr_cnt_q   <= '0;
      sum_q      <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      wr_cnt_q   <= wr_cnt_d;
      sum_q      <= sum_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
    end
  end

  // Array clears on reset so an aborted burst leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[ptr_q] <= in_data;
    end
  end

  assign spo      = mem_q[addr];
  assign in_ready = in_ready_q;
  assign busy     = in_ready_q;
  assign done     = done_q;
  assign wr_cnt   = wr_cnt_q;
  assign sum      = sum_q;

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: stimulus queues expected done/readback results,
// a negedge monitor pops and compares them when the DUT presents them.
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  base;
  logic [4:0]  len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [3:0]  addr;
  logic [15:0] spo;
  logic        busy;
  logic        done;
  logic [4:0]  wr_cnt;
  logic [15:0] sum;

  int total = 0;
  int bad   = 0;

  logic [20:0] done_q[$];
  logic [15:0] rd_q[$];
  logic        rd_req = 1'b0;

  ram_loader #(
    .DATA_W(16),
    .ADDR_W(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .base    (base),
    .len     (len),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .addr    (addr),
    .spo     (spo),
    .busy    (busy),
    .done    (done),
    .wr_cnt  (wr_cnt),
    .sum     (sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: done pulses and readback strobes are checked against the queues.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got done=1 expected no pulse (t=%0t)", $time);
      end else begin
        chk("done_cnt_sum", {11'd0, wr_cnt, sum}, {11'd0, done_q.pop_front()});
      end
    end
    if (rd_req) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_underflow: got strobe expected queued word (t=%0t)", $time);
      end else begin
        chk($sformatf("spo[%0d]", addr), {16'd0, spo}, {16'd0, rd_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp);
    rd_q.push_back(exp);
    addr   = a;
    rd_req = 1'b1;
    @(negedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  // vpat bit c gives in_valid on LOAD cycle c; mid injects a start on cycle 1.
  task automatic burst(input logic [3:0] b, input logic [4:0] l, input logic [15:0] d [16],
                       input logic [15:0] vpat, input bit mid, input logic [15:0] exp_sum);
    int i;
    int c;
    done_q.push_back({l, exp_sum});
    start = 1'b1;
    base  = b;
    len   = l;
    step();
    start = 1'b0;
    i = 0;
    c = 0;
    while (i < int'(l) && c < 64) begin
      in_valid = vpat[c % 16];
      in_data  = in_valid ? d[i] : 16'hDEAD;
      if (mid && c == 1) begin
        start = 1'b1;
        base  = 4'd9;
        len   = 5'd1;
      end else begin
        start = 1'b0;
      end
      chk("in_ready_load", {31'd0, in_ready}, 32'd1);
      step();
      if (in_valid) i++;
      c++;
    end
    if (c >= 64) chk("burst_timeout", c, 32'd0);
    start    = 1'b0;
    in_valid = 1'b0;
    chk("done_at_end", {31'd0, done}, 32'd1);
    chk("busy_at_end", {31'd0, busy}, 32'd0);
    step();
    chk("done_after", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [15:0] d [16];
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d [16];
    rst_n    = 1'b0;
    start    = 1'b0;
    base     = '0;
    len      = '0;
    in_valid = 1'b0;
    in_data  = '0;
    addr     = '0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_cnt", {27'd0, wr_cnt}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) rd(4'(a), 16'h0000);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);

    // Full 16-word burst from address 0, valid held high.
    for (int k = 0; k < 16; k++) d[k] = 16'h1000 + 16'(k);
    burst(4'd0, 5'd16, d, 16'hFFFF, 1'b0, 16'h0078);
    chk("b1_wr_cnt", {27'd0, wr_cnt}, 32'd16);
    for (int a = 0; a < 16; a++) rd(4'(a), 16'h1000 + 16'(a));

    // Wrap-around burst, 14,15,0,1.
    d[0] = 16'hAAAA; d[1] = 16'hBBBB; d[2] = 16'hCCCC; d[3] = 16'hDDDD;
    burst(4'd14, 5'd4, d, 16'hFFFF, 1'b0, 16'h110E);
    rd(4'd14, 16'hAAAA);
    rd(4'd15, 16'hBBBB);
    rd(4'd0, 16'hCCCC);
    rd(4'd1, 16'hDDDD);
    rd(4'd2, 16'h1002);

    // Stalled burst with a start pulse mid-burst that must be ignored.
    d[0] = 16'h0011; d[1] = 16'h0022; d[2] = 16'h0033;
    burst(4'd4, 5'd3, d, 16'h0049, 1'b1, 16'h0066);
    rd(4'd4, 16'h0011);
    rd(4'd5, 16'h0022);
    rd(4'd6, 16'h0033);
    rd(4'd7, 16'h1007);
    rd(4'd9, 16'h1009);
    chk("hold_wr_cnt", {27'd0, wr_cnt}, 32'd3);
    chk("hold_sum", {16'd0, sum}, 32'h0066);

    // Zero-length burst goes straight to DONE.
    burst(4'd4, 5'd0, d, 16'hFFFF, 1'b0, 16'h0000);
    rd(4'd4, 16'h0011);
    rd(4'd0, 16'hCCCC);

    // Reset in the middle of a 5-word burst.
    start = 1'b1;
    base  = 4'd8;
    len   = 5'd5;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h7777;
    step();
    in_data = 16'h8888;
    step();
    chk("pre_rst_cnt", {27'd0, wr_cnt}, 32'd2);
    rst_n = 1'b0;
    #1;
    addr = 4'd8;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_wr_cnt", {27'd0, wr_cnt}, 32'd0);
    chk("abort_sum", {16'd0, sum}, 32'd0);
    chk("abort_spo", {16'd0, spo}, 32'd0);
    in_valid = 1'b0;
    step();
    step();
    // Start sampled on the first edge after release is accepted.
    rst_n = 1'b1;
    d[0] = 16'h5A5A;
    burst(4'd3, 5'd1, d, 16'hFFFF, 1'b0, 16'h5A5A);
    for (int a = 0; a < 16; a++) rd(4'(a), (a == 3) ? 16'h5A5A : 16'h0000);

    step();
    step();
    chk("done_q_empty", done_q.size(), 32'd0);
    chk("rd_q_empty", rd_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
